// File: rtl/div_seq_ctrl.sv
// Sequential 32-bit restoring divider controller for the EX stage (DIV/DIVU).
// One quotient bit per cycle; stalls the pipeline until the result is ready.
module div_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        annul,
    output logic        stall_req,
    output logic        ready,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [64:0] rq;
    logic [31:0] dvs;
    logic        sign_q;
    logic        sign_r;
    logic [64:0] rq_next;

    // |x| of a two's complement word; 0x80000000 maps to itself, read as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [31:0] cond_neg(input logic [31:0] x, input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

    // One restoring step: upper 33 bits hold the partial remainder, lower 32 the quotient.
    function automatic logic [64:0] div_step(input logic [64:0] r, input logic [31:0] d);
        logic [64:0] sh;
        sh = {r[63:0], 1'b0};
        if (sh[64:32] >= {1'b0, d}) begin
            sh[64:32] = sh[64:32] - {1'b0, d};
            sh[0]     = 1'b1;
        end
        return sh;
    endfunction

    always_comb begin
        rq_next = div_step(rq, dvs);
    end

    assign stall_req = ((state == IDLE) && start && !annul) || (state == ON) || (state == DIVZERO);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 6'd0;
            rq     <= 65'd0;
            dvs    <= 32'd0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            ready  <= 1'b0;
            hi_out <= 32'd0;
            lo_out <= 32'd0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !annul) begin
                        rq     <= {33'd0, signed_div ? abs32(opa) : opa};
                        dvs    <= signed_div ? abs32(opb) : opb;
                        sign_q <= signed_div & (opa[31] ^ opb[31]);
                        sign_r <= signed_div & opa[31];
                        cnt    <= 6'd0;
                        state  <= (opb == 32'd0) ? DIVZERO : ON;
                    end
                end
                DIVZERO: begin
                    if (annul) begin
                        state <= IDLE;
                    end else begin
                        hi_out <= 32'd0;
                        lo_out <= 32'd0;
                        ready  <= 1'b1;
                        state  <= END;
                    end
                end
                ON: begin
                    if (annul) begin
                        state <= IDLE;
                    end else begin
                        rq  <= rq_next;
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            lo_out <= cond_neg(rq_next[31:0], sign_q);
                            hi_out <= cond_neg(rq_next[63:32], sign_r);
                            ready  <= 1'b1;
                            state  <= END;
                        end
                    end
                end
                END: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: latency, signed/unsigned results, div-by-zero,
// annul, reset mid-operation and back-to-back starts.
module tb_div_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        annul;
    logic        stall_req;
    logic        ready;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_checks;
    int n_pass;

    div_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opa        (opa),
        .opb        (opb),
        .annul      (annul),
        .stall_req  (stall_req),
        .ready      (ready),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // Issues one operation and waits (bounded) for ready; cycle T is the acceptance cycle.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sd, input int exp_lat,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int k;
        int stall_bad;
        @(negedge clk);
        chk({tag, "_rdy_idle"}, {31'd0, ready}, 32'd0);
        opa = a; opb = b; signed_div = sd; start = 1'b1;
        #1;
        chk({tag, "_stall_T"}, {31'd0, stall_req}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        k = 1;
        stall_bad = 0;
        while (k <= 40 && !ready) begin
            if (!stall_req) stall_bad++;
            if (k == 5) begin
                opa = ~a;
                opb = b + 32'd3;
                signed_div = ~sd;
            end
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"}, k, exp_lat);
        chk({tag, "_stall_busy"}, stall_bad, 32'd0);
        chk({tag, "_lo"}, lo_out, exp_lo);
        chk({tag, "_hi"}, hi_out, exp_hi);
        chk({tag, "_stall_end"}, {31'd0, stall_req}, 32'd0);
    endtask

    initial begin
        int seen;
        n_checks = 0;
        n_pass = 0;
        rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
        opa = 32'd0; opb = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        rst = 1'b0;

        run_op("u100_7", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2);
        run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 32'h8000_0000, 32'd0);
        run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 33, 32'hFFFF_FFFD, 32'd1);
        run_op("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 33, 32'hFFFF_FFFF, 32'd0);
        run_op("u_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33, 32'd1, 32'd0);
        run_op("u5_9", 32'd5, 32'd9, 1'b0, 33, 32'd0, 32'd5);
        run_op("dz", 32'h1234, 32'd0, 1'b0, 2, 32'd0, 32'd0);
        run_op("u100_7b", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2);

        // Annul during ON: annul in cycle T+10, IDLE at T+11, outputs held.
        @(negedge clk);
        opa = 32'h1234; opb = 32'd3; signed_div = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 1; i < 10; i++) begin
            if (ready) seen++;
            @(negedge clk);
        end
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        #1;
        chk("annul_on_idle", {31'd0, stall_req}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (ready) seen++;
            @(negedge clk);
        end
        chk("annul_on_noready", seen, 32'd0);
        chk("annul_on_lo", lo_out, 32'd14);
        chk("annul_on_hi", hi_out, 32'd2);

        // Annul during DIVZERO: no ready, outputs not zeroed.
        opa = 32'h55; opb = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (ready) seen++;
            @(negedge clk);
        end
        chk("annul_dz_noready", seen, 32'd0);
        chk("annul_dz_lo", lo_out, 32'd14);
        chk("annul_dz_hi", hi_out, 32'd2);

        // Reset at T+20 of an operation, then restart at T+22.
        opa = 32'd1000; opb = 32'd3; signed_div = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ready", {31'd0, ready}, 32'd0);
        chk("rst_mid_hi", hi_out, 32'd0);
        chk("rst_mid_lo", lo_out, 32'd0);
        chk("rst_mid_stall", {31'd0, stall_req}, 32'd0);
        run_op("restart", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2);

        // Annul held during END must not cancel the ready pulse already issued.
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        chk("end_annul_lo", lo_out, 32'd14);
        chk("post_end_ready", {31'd0, ready}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
